sum_accumulator: RTL and testbench

Batch accumulator directly downstream of the 2-bit ripple adder. Consumes its 3-bit sum (0..7) over a valid/ready handshake and adds COUNT consecutive samples into a wide register. Presents the batch total on an output valid/ready handshake. Used to sum a stream of 2-bit additions without widening the adder itself.

---
 rtl/adder_pkg.sv | 14 +
 rtl/sample_counter.sv | 32 +++
 rtl/sum_accumulator.sv | 116 +++++++++++
 tb/tb_sum_accumulator.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder datapath blocks.
// FSM state encoding plus adder and counter widths.
package adder_pkg;

  localparam int SUM_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/sample_counter.sv
// Counts accepted samples in a batch; tc flags COUNT-1.
// Ports: clk, rst, clr, en -> tc.
module sample_counter
  import adder_pkg::*;
#(
  parameter int COUNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(COUNT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/sum_accumulator.sv
// Batch accumulator: adds COUNT 3-bit samples, presents total.
// Ports: clk, rst, start, in_valid/in_ready/in_sum,
//   out_valid/out_ready/acc_out, busy, overflow.
// Option: ACC_SATURATE_EN clamps acc_out on overflow.
module sum_accumulator
  import adder_pkg::*;
#(
  parameter int ACC_W = 8,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             busy,
  output logic             overflow
);

  state_t state_q;
  state_t state_d;

  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic             accept;
  logic             clr;
  logic             tc;

  assign accept  = (state_q == ACCUM) & in_valid;
  assign sum_ext = {1'b0, acc_q}
                 + (ACC_W + 1)'(in_sum);
  assign carry   = sum_ext[ACC_W];

  sample_counter #(
    .COUNT(COUNT)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .en (accept),
    .tc (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          clr     = 1'b1;
        end
      end
      ACCUM: begin
        if (in_valid && tc) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= ovf_q | carry;
`ifdef ACC_SATURATE_EN
      // once clamped, stay pinned for the batch
      if (ovf_q || carry) begin
        acc_q <= ACC_MAX;
      end else begin
        acc_q <= sum_ext[ACC_W-1:0];
      end
`else
      acc_q <= sum_ext[ACC_W-1:0];
`endif
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = in_ready | out_valid;
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator.
// Instances: 8-bit/COUNT=4, 4-bit/COUNT=4, 8-bit/COUNT=1.
module tb_sum_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] in_sum = '0;

  logic       n_ir, n_ov, n_bs, n_of;
  logic [7:0] n_acc;
  logic       w_ir, w_ov, w_bs, w_of;
  logic [3:0] w_acc;

  logic       c_start = 1'b0;
  logic       c_valid = 1'b0;
  logic       c_ready = 1'b0;
  logic [2:0] c_sum = '0;
  logic       c_ir, c_ov, c_bs, c_of;
  logic [7:0] c_acc;

  sum_accumulator #(.ACC_W(8), .COUNT(4)) u_n (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(n_ir),
    .in_sum(in_sum), .out_valid(n_ov),
    .out_ready(out_ready), .acc_out(n_acc),
    .busy(n_bs), .overflow(n_of)
  );

  sum_accumulator #(.ACC_W(4), .COUNT(4)) u_w (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(w_ir),
    .in_sum(in_sum), .out_valid(w_ov),
    .out_ready(out_ready), .acc_out(w_acc),
    .busy(w_bs), .overflow(w_of)
  );

  sum_accumulator #(.ACC_W(8), .COUNT(1)) u_c (
    .clk(clk), .rst(rst), .start(c_start),
    .in_valid(c_valid), .in_ready(c_ir),
    .in_sum(c_sum), .out_valid(c_ov),
    .out_ready(c_ready), .acc_out(c_acc),
    .busy(c_bs), .overflow(c_of)
  );

  typedef struct {
    logic [3:0][2:0] s;
    int gap;
    int hold;
    bit smid;
    bit sdrain;
    int e8;
    bit o8;
  } row_t;

  typedef struct {
    int a8;
    bit o8;
    int a4;
    bit o4;
  } exp_t;

  exp_t sb[$];
  row_t tbl[5];
  int   total = 0;
  int   bad = 0;
  int   last8 = 0;

  task automatic chk(input string nm,
                     input int act,
                     input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d",
               nm, act, req);
    end
  endtask

  function automatic row_t mk(
    input int a, input int b,
    input int c, input int d,
    input int gap, input int hold,
    input bit smid, input bit sdrain,
    input int e8, input bit o8);
    row_t r;
    r.s[0] = 3'(a);
    r.s[1] = 3'(b);
    r.s[2] = 3'(c);
    r.s[3] = 3'(d);
    r.gap = gap;
    r.hold = hold;
    r.smid = smid;
    r.sdrain = sdrain;
    r.e8 = e8;
    r.o8 = o8;
    return r;
  endfunction

  // reference model for the 4-bit instance
  task automatic m4(input row_t r,
                    output int a,
                    output bit o);
    int s;
    a = 0;
    o = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = a + int'(r.s[i]);
      if (s > 15) o = 1'b1;
`ifdef ACC_SATURATE_EN
      a = o ? 15 : s;
`else
      a = s % 16;
`endif
    end
  endtask

  task automatic run_row(input row_t r);
    exp_t e;
    int   a4;
    bit   o4;
    int   cyc;
    m4(r, a4, o4);
    e.a8 = r.e8;
    e.o8 = r.o8;
    e.a4 = a4;
    e.o4 = o4;
    sb.push_back(e);
    cyc = 0;
    start = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    chk("accum_ready", int'(n_ir), 1);
    chk("accum_busy", int'(n_bs), 1);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < r.gap; g++) begin
        in_valid = 1'b0;
        @(negedge clk);
        cyc++;
      end
      in_valid = 1'b1;
      in_sum = r.s[i];
      start = r.smid && (i == 1);
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (i == 2) chk("early_done", int'(n_ov), 0);
    end
    in_valid = 1'b0;
    chk("done_valid", int'(n_ov), 1);
    chk("done_ready", int'(n_ir), 0);
    chk("done_valid_w", int'(w_ov), 1);
    if (r.gap == 0) chk("latency", cyc, 5);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("acc8", int'(n_acc), e.a8);
      chk("ovf8", int'(n_of), int'(e.o8));
      chk("acc4", int'(w_acc), e.a4);
      chk("ovf4", int'(w_of), int'(e.o4));
    end
    for (int h = 0; h < r.hold; h++) begin
      out_ready = 1'b0;
      @(negedge clk);
      chk("hold_valid", int'(n_ov), 1);
      chk("hold_acc", int'(n_acc), e.a8);
    end
    out_ready = 1'b1;
    start = r.sdrain;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    chk("idle_valid", int'(n_ov), 0);
    chk("idle_busy", int'(n_bs), 0);
    chk("idle_acc", int'(n_acc), e.a8);
    chk("idle_ovf4", int'(w_of), int'(e.o4));
    if (r.sdrain) begin
      @(negedge clk);
      chk("no_new_busy", int'(n_bs), 0);
      chk("no_new_ready", int'(n_ir), 0);
    end
    last8 = e.a8;
  endtask

  initial begin
    tbl[0] = mk(7, 7, 7, 7, 0, 0, 0, 0, 28, 0);
    tbl[1] = mk(1, 0, 3, 6, 2, 5, 0, 0, 10, 0);
    tbl[2] = mk(5, 5, 5, 1, 0, 1, 1, 0, 16, 0);
    tbl[3] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    tbl[4] = mk(2, 3, 4, 3, 0, 2, 0, 0, 12, 0);

    @(negedge clk);
    chk("rst_acc", int'(n_acc), 0);
    chk("rst_valid", int'(n_ov), 0);
    chk("rst_ready", int'(n_ir), 0);
    chk("rst_busy", int'(n_bs), 0);
    chk("rst_ovf", int'(n_of), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      run_row(tbl[k]);
      if (k == 0) begin
        in_valid = 1'b1;
        in_sum = 3'd7;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("idle_in_ready", int'(n_ir), 0);
          chk("idle_in_acc", int'(n_acc), last8);
        end
        in_valid = 1'b0;
      end
    end

    // abort mid-batch with async reset
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_sum = 3'd5;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("partial_acc", int'(n_acc), 10);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_acc", int'(n_acc), 0);
    chk("arst_busy", int'(n_bs), 0);
    chk("arst_ready", int'(n_ir), 0);
    chk("arst_valid", int'(n_ov), 0);
    chk("arst_ovf", int'(n_of), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_row(mk(1, 2, 3, 4, 0, 0, 0, 0, 10, 0));

    // single-sample batch
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    chk("c1_ready", int'(c_ir), 1);
    c_valid = 1'b1;
    c_sum = 3'd6;
    @(negedge clk);
    c_valid = 1'b0;
    chk("c1_valid", int'(c_ov), 1);
    chk("c1_acc", int'(c_acc), 6);
    chk("c1_ovf", int'(c_of), 0);
    c_ready = 1'b1;
    @(negedge clk);
    c_ready = 1'b0;
    chk("c1_idle", int'(c_ov), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
